param_load_counter: RTL and testbench

- Parametrised load/count timer; successor to the fixed 32-bit free-running down counter.
- Adds configurable width, an up/down direction, one-shot or auto-reload mode, a clock prescaler, count enable, a terminal-count pulse and done/busy status.
- `count_data` drives the seg7 display path.
- `tc` feeds interrupt or sequencing logic elsewhere in the CPU-side design.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/param_load_counter_if.sv | 34 +++
 rtl/prescaler_tick.sv | 41 ++++
 rtl/param_load_counter.sv | 107 ++++++++++
 tb/tb_param_load_counter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the parametrised load/count timer and its consumers
// (the seg7 display path uses the default width and prescale values).
//   - 2-bit state encoding for the timer FSM (IDLE / RUN / DONE)
//   - direction encoding (DIR_DOWN / DIR_UP)
//   - default WIDTH / PRESCALE / PS_W values
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_PRESCALE = 1;
    localparam int DEFAULT_PS_W     = 16;

endpackage

// File: rtl/param_load_counter_if.sv
// -----------------------------------------------------------------------------
// param_load_counter_if
// Control/status bundle of the load/count timer.
//   master : drives load, init_data, en, dir, auto_reload;
//            observes count_data, tc, busy, done
//   slave  : the timer itself (the reverse directions)
// -----------------------------------------------------------------------------
interface param_load_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] init_data;
    logic             en;
    logic             dir;
    logic             auto_reload;
    logic [WIDTH-1:0] count_data;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, init_data, en, dir, auto_reload,
        input  count_data, tc, busy, done
    );

    modport slave (
        input  load, init_data, en, dir, auto_reload,
        output count_data, tc, busy, done
    );

endinterface

// File: rtl/prescaler_tick.sv
// -----------------------------------------------------------------------------
// prescaler_tick
// Divides enabled clock cycles by PRESCALE and flags the cycle on which the
// timer should take a count step.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   clr   : synchronous clear (timer load), wins over en
//   en    : advance the prescaler this cycle; 0 freezes it
//   tick  : combinational, high when en && count == PRESCALE-1
// -----------------------------------------------------------------------------
module prescaler_tick #(
    parameter int PRESCALE = 1,
    parameter int PS_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] ONE  = PS_W'(1);

    logic [PS_W-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            // Wrap on the step cycle so the next step is a full PRESCALE away.
            count <= tick ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/param_load_counter.sv
// -----------------------------------------------------------------------------
// param_load_counter
// Parametrised load/count timer: loads init_data (also kept as the reload
// value), then steps down or up once every PRESCALE enabled cycles. At the
// terminal value (0 counting down, all-ones counting up) it pulses tc for one
// cycle and either reloads (auto_reload=1) or stops in DONE (one-shot).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of param_load_counter_if
//           in : load, init_data, en, dir, auto_reload
//           out: count_data (to seg7), tc (to interrupt/sequencing),
//                busy (in RUN), done (one-shot expired)
// -----------------------------------------------------------------------------
module param_load_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PS_W     = DEFAULT_PS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    param_load_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;
    logic             tc;
    logic             busy;
    logic             done;
    logic             run_en;
    logic             tick;

    function automatic logic [WIDTH-1:0] terminal_of(input logic d);
        return (d == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    // The prescaler only advances while running; en is ignored in IDLE/DONE.
    assign run_en = bus.en && (state == RUN);

    prescaler_tick #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.load),
        .en    (run_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (bus.load) begin
                // Load overrides enable and any terminal step on the same edge.
                state  <= RUN;
                count  <= bus.init_data;
                reload <= bus.init_data;
                busy   <= 1'b1;
                done   <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (tick) begin
                            // Terminal check before arithmetic: never wrap.
                            if (count == terminal_of(bus.dir)) begin
                                tc <= 1'b1;
                                if (bus.auto_reload) begin
                                    count <= reload;
                                end else begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else if (bus.dir == DIR_UP) begin
                                count <= count + ONE;
                            end else begin
                                count <= count - ONE;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until the next load.
                    end
                endcase
            end
        end
    end

    assign bus.count_data = count;
    assign bus.tc         = tc;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_param_load_counter.sv
// -----------------------------------------------------------------------------
// tb_param_load_counter
// Two 8-bit instances: dut1 with PRESCALE=1 driven from a vector table,
// dut4 with PRESCALE=4 exercised by a hand-written enable-gap sequence.
// Asynchronous reset is checked between clock edges.
// -----------------------------------------------------------------------------
module tb_param_load_counter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_load_counter_if #(.WIDTH(8)) bus1 ();
    param_load_counter_if #(.WIDTH(8)) bus4 ();

    param_load_counter #(.WIDTH(8), .PRESCALE(1), .PS_W(16)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    param_load_counter #(.WIDTH(8), .PRESCALE(4), .PS_W(3)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    typedef struct {
        logic       load;
        logic [7:0] init;
        logic       en;
        logic       dir;
        logic       ar;
        logic [7:0] e_count;
        logic       e_tc;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic l, input logic [7:0] i, input logic e,
                       input logic d, input logic a, input logic [7:0] c,
                       input logic t, input logic b, input logic dn);
        vec_t v;
        v.load = l; v.init = i; v.en = e; v.dir = d; v.ar = a;
        v.e_count = c; v.e_tc = t; v.e_busy = b; v.e_done = dn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all1(input string nm, input int idx, input logic [7:0] c,
                            input logic t, input logic b, input logic dn);
        chk({nm, "_count"}, idx, 32'(bus1.count_data), 32'(c));
        chk({nm, "_tc"},    idx, 32'(bus1.tc),         32'(t));
        chk({nm, "_busy"},  idx, 32'(bus1.busy),       32'(b));
        chk({nm, "_done"},  idx, 32'(bus1.done),       32'(dn));
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset/load one-shot down from 5
        add(1, 8'd5,   1, 0, 0, 8'd5,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd4,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd3,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd2,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd1,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd0,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd0,   1, 0, 1);
        add(0, 8'd0,   1, 0, 0, 8'd0,   0, 0, 1);
        add(0, 8'd0,   1, 0, 0, 8'd0,   0, 0, 1);
        // en=0 freezes RUN
        add(1, 8'd9,   0, 0, 0, 8'd9,   0, 1, 0);
        add(0, 8'd0,   0, 0, 0, 8'd9,   0, 1, 0);
        add(0, 8'd0,   0, 0, 0, 8'd9,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd8,   0, 1, 0);
        // Auto-reload from 3
        add(1, 8'd3,   1, 0, 1, 8'd3,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd2,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd1,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd0,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd3,   1, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd2,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd1,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd0,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd3,   1, 1, 0);
        // Up count one-shot near all-ones, no wrap
        add(1, 8'hFD,  1, 1, 0, 8'hFD,  0, 1, 0);
        add(0, 8'd0,   1, 1, 0, 8'hFE,  0, 1, 0);
        add(0, 8'd0,   1, 1, 0, 8'hFF,  0, 1, 0);
        add(0, 8'd0,   1, 1, 0, 8'hFF,  1, 0, 1);
        add(0, 8'd0,   1, 1, 0, 8'hFF,  0, 0, 1);
        add(0, 8'd0,   1, 1, 0, 8'hFF,  0, 0, 1);
        // Load on the same edge as a terminal step
        add(1, 8'd2,   1, 0, 1, 8'd2,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd1,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd0,   0, 1, 0);
        add(1, 8'd7,   1, 0, 1, 8'd7,   0, 1, 0);
        add(0, 8'd0,   1, 0, 1, 8'd6,   0, 1, 0);
        // Loading the terminal value gives tc on the first step
        add(1, 8'd0,   1, 0, 0, 8'd0,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd0,   1, 0, 1);
        // Direction change mid-run
        add(1, 8'd5,   1, 0, 0, 8'd5,   0, 1, 0);
        add(0, 8'd0,   1, 1, 0, 8'd6,   0, 1, 0);
        add(0, 8'd0,   1, 0, 0, 8'd5,   0, 1, 0);
        // Up count with auto-reload
        add(1, 8'hFE,  1, 1, 1, 8'hFE,  0, 1, 0);
        add(0, 8'd0,   1, 1, 1, 8'hFF,  0, 1, 0);
        add(0, 8'd0,   1, 1, 1, 8'hFE,  1, 1, 0);

        bus1.load = 0; bus1.init_data = '0; bus1.en = 0; bus1.dir = 0; bus1.auto_reload = 0;
        bus4.load = 0; bus4.init_data = '0; bus4.en = 0; bus4.dir = 0; bus4.auto_reload = 0;
        reset = 1'b0;
        #2;
        chk_all1("reset", 0, 8'd0, 0, 0, 0);
        chk("reset4_count", 0, 32'(bus4.count_data), 32'd0);
        tick1();
        tick1();
        reset = 1'b1;

        // IDLE ignores en
        bus1.en = 1;
        tick1();
        tick1();
        chk_all1("idle", 0, 8'd0, 0, 0, 0);

        // Async reset mid-count, applied between edges
        bus1.load = 1; bus1.init_data = 8'd5;
        tick1();
        bus1.load = 0;
        tick1();
        tick1();
        chk_all1("precount", 0, 8'd3, 0, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        chk_all1("async_rst", 0, 8'd0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tick1();
            chk_all1("rst_hold", k, 8'd0, 0, 0, 0);
        end
        reset = 1'b1;
        tick1();
        chk_all1("rst_rel", 0, 8'd0, 0, 0, 0);

        // Table-driven vectors on dut1
        for (int i = 0; i < vecs.size(); i++) begin
            bus1.load        = vecs[i].load;
            bus1.init_data   = vecs[i].init;
            bus1.en          = vecs[i].en;
            bus1.dir         = vecs[i].dir;
            bus1.auto_reload = vecs[i].ar;
            tick1();
            chk_all1("vec", i, vecs[i].e_count, vecs[i].e_tc, vecs[i].e_busy, vecs[i].e_done);
        end
        bus1.load = 0;
        bus1.en   = 0;

        // PRESCALE=4 with a 3-cycle enable gap
        bus4.load = 1; bus4.init_data = 8'd2; bus4.en = 1; bus4.dir = 0; bus4.auto_reload = 0;
        tick1();
        bus4.load = 0;
        chk("ps_load_count", 0, 32'(bus4.count_data), 32'd2);
        chk("ps_load_busy",  0, 32'(bus4.busy),       32'd1);
        for (int e = 1; e <= 13; e++) begin
            if (e == 7) begin
                bus4.en = 0;
                for (int k = 0; k < 3; k++) begin
                    tick1();
                    chk("ps_gap_count", k, 32'(bus4.count_data), 32'd1);
                    chk("ps_gap_tc",    k, 32'(bus4.tc),         32'd0);
                end
                bus4.en = 1;
            end
            tick1();
            chk("ps_count", e, 32'(bus4.count_data),
                32'((e < 4) ? 2 : ((e < 8) ? 1 : 0)));
            chk("ps_tc", e, 32'(bus4.tc), 32'((e == 12) ? 1 : 0));
        end
        chk("ps_done", 0, 32'(bus4.done), 32'd1);
        chk("ps_busy", 0, 32'(bus4.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
